// File: rtl/srcb_pkg.sv
// Shared definitions for the ALU source-B operand stage: mode encodings,
// the operand record layout and the legal-mode check.
package srcb_pkg;

  localparam logic [2:0] SRCB_REG      = 3'b000;
  localparam logic [2:0] SRCB_INC      = 3'b001;
  localparam logic [2:0] SRCB_SEXT     = 3'b010;
  localparam logic [2:0] SRCB_SEXT_SHL = 3'b011;
  localparam logic [2:0] SRCB_ZEXT     = 3'b100;
  localparam logic [2:0] SRCB_LUI      = 3'b101;

  // Reference layout at the default 32-bit width; the top level declares
  // the same {data, sel} record at its own WIDTH.
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  sel;
  } srcb_operand_t;

  function automatic logic is_legal_sel(input logic [2:0] s);
    return (s <= SRCB_LUI);
  endfunction

endpackage

// File: rtl/srcb_skid_buffer.sv
// Generic 2-entry registered skid buffer with valid/ready handshakes.
// in_ready and out_valid are decoded from the state register only.
module srcb_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t     state, state_next;
  logic [W-1:0] head, skid;
  logic       push, pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (!push && pop) state_next = EMPTY;
      end
      FULL:  if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_next;
      // The head only reloads when it is free or being consumed; otherwise
      // a new entry parks in the skid slot.
      unique case (state)
        EMPTY: if (push) head <= in_data;
        ONE: begin
          if (push && pop)  head <= in_data;
          else if (push)    skid <= in_data;
        end
        FULL:  if (pop) head <= skid;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/srcb_operand_stage.sv
// Registered ALU source-B operand select: forms the operand from the chosen
// mode, tracks illegal modes in a sticky flag and queues through a skid buffer.
module srcb_operand_stage
  import srcb_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 16,
  parameter int unsigned SHAMT     = 2,
  parameter int unsigned CONST_INC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     b_reg,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [2:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_sel,
  input  logic                 err_clr,
  output logic                 err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       sel;
  } operand_t;

  operand_t         operand_in, operand_out;
  logic [WIDTH-1:0] sext_imm, zext_imm, lui_imm;
  logic             push;

  assign sext_imm = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign zext_imm = {{(WIDTH-IMM_WIDTH){1'b0}}, imm};
  assign lui_imm  = {imm, {(WIDTH-IMM_WIDTH){1'b0}}};
  assign push     = in_valid && in_ready;

  always_comb begin
    operand_in.data = '0;
    operand_in.sel  = sel;
    case (sel)
      SRCB_REG:      operand_in.data = b_reg;
      SRCB_INC:      operand_in.data = WIDTH'(CONST_INC);
      SRCB_SEXT:     operand_in.data = sext_imm;
      SRCB_SEXT_SHL: operand_in.data = sext_imm << SHAMT;
      SRCB_ZEXT:     operand_in.data = zext_imm;
      SRCB_LUI:      operand_in.data = lui_imm;
      default:       operand_in.data = '0;
    endcase
  end

  // Setting on an illegal push takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)                           err <= 1'b0;
    else if (push && !is_legal_sel(sel)) err <= 1'b1;
    else if (err_clr)                    err <= 1'b0;
  end

  srcb_skid_buffer #(
    .W($bits(operand_t))
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (operand_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (operand_out)
  );

  assign out_data = operand_out.data;
  assign out_sel  = operand_out.sel;

endmodule

// File: doc/srcb_operand_stage.md
Name: srcb_operand_stage

Overview:
- Parametrised, registered successor to the ALU source-B operand select in the multicycle MIPS datapath.
- Selects the ALU B operand from six modes: register B, the PC increment constant, sign-extended immediate, shifted sign-extended immediate, zero-extended immediate, and upper immediate (LUI).
- Delivers the operand through a 2-entry skid buffer with a valid/ready handshake, so the control FSM can stall the ALU without losing operands.
- Sits between the register-file/immediate stage and the ALU B input.

Parameters:
- WIDTH, 32, datapath width in bits; must satisfy WIDTH > IMM_WIDTH.
- IMM_WIDTH, 16, raw immediate width in bits.
- SHAMT, 2, left-shift amount for the branch-offset mode.
- CONST_INC, 4, constant driven in the increment mode.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source offers an operand request this cycle.
- in_ready  output  1  stage can accept a request.
- b_reg  input  WIDTH  register B value.
- imm  input  IMM_WIDTH  raw instruction immediate.
- sel  input  3  operand mode select.
- out_valid  output  1  out_data holds a valid operand.
- out_ready  input  1  ALU consumes the operand this cycle.
- out_data  output  WIDTH  selected operand.
- out_sel  output  3  mode tag travelling with out_data.
- err_clr  input  1  clears sticky err.
- err  output  1  sticky flag: an illegal sel was accepted.

Behaviour:
- Handshakes:
  - A push happens when in_valid && in_ready.
  - A pop happens when out_valid && out_ready.
  - Inputs are sampled only on a push.
- Mode encoding, computed combinationally at push and stored as {data, sel}:
  - 000: b_reg.
  - 001: CONST_INC, zero-extended to WIDTH.
  - 010: sign-extend imm to WIDTH.
  - 011: sign-extend imm to WIDTH, then shift left by SHAMT, truncated to WIDTH.
  - 100: zero-extend imm to WIDTH.
  - 101: imm placed in bits [WIDTH-1:WIDTH-IMM_WIDTH], lower bits zero.
  - 110, 111: illegal. Store data = 0 and set err in the same clock edge as the push.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push without pop -> FULL.
  - ONE + pop without push -> EMPTY.
  - ONE + push and pop -> ONE, with the new entry at the head on the next cycle.
  - FULL + pop -> ONE, with the skid entry moving to the head.
  - FULL never pushes, because in_ready=0.
- Latency: 1 cycle from push to out_valid when EMPTY; out_data and out_sel are registered, with no combinational input-to-output path.
- in_ready depends only on state (registered), never on out_ready.
- Order: strict FIFO, no entry dropped or duplicated.
- Hold: out_data and out_sel stay stable while out_valid && !out_ready.
- err:
  - Sticky once set.
  - err_clr clears it on the next edge.
  - If err_clr and an illegal push happen in the same cycle, err remains 1 (set wins).
- reset, including mid-transfer:
  - Next edge: state EMPTY, out_valid=0, out_data=0, out_sel=000, err=0, in_ready=1.
  - Buffered entries are discarded.
  - Inputs in the reset cycle are ignored.

Decomposition:
- Package srcb_pkg: 3-bit mode constants SRCB_REG, SRCB_INC, SRCB_SEXT, SRCB_SEXT_SHL, SRCB_ZEXT, SRCB_LUI; an operand struct typedef {data, sel}; a function is_legal_sel.
- Sub-module srcb_skid_buffer: a generic 2-entry registered skid buffer parametrised on payload width. The top level contains only the operand-formation logic, the err register, and one buffer instance.

Test Plan:
- Reset, then push sel=010, imm=16'hFFFC -> next cycle out_valid=1, out_data=32'hFFFFFFFC, out_sel=010.
- Push sel=011, imm=16'h8001, out_ready=1 -> out_data=32'hFFFE0004. Push sel=101, imm=16'h1234 -> out_data=32'h12340000. Push sel=100, imm=16'h8000 -> out_data=32'h00008000.
- Hold out_ready=0 and push 001 then 000 (b_reg=32'hDEADBEEF) -> in_ready falls to 0 after the second push. out_data holds 4 while stalled. Raise out_ready -> 4 pops, then 32'hDEADBEEF pops, then out_valid=0.
- Streaming: in_valid=out_ready=1 for 8 cycles with distinct b_reg values -> one operand per cycle, in order, in_ready stays 1.
- Push sel=111 -> out_data=0, err=1. Assert err_clr for one cycle -> err=0. Assert err_clr together with another illegal push -> err stays 1.
- FULL state, then assert reset for one cycle -> out_valid=0, in_ready=1, err=0. The next push appears after 1 cycle with correct data.
